// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register busy scoreboard.
//
// One synchronous write port, two combinational read ports and a claim
// port used by issue logic to mark a destination register busy. Writeback
// clears the busy bit. An optional hardwired zero register, optional
// write-to-read bypass and a flush of all busy bits are provided.
//
// Ports:
//   clk                     clock, rising edge
//   reset                   asynchronous, active-low; clears data and busy bits
//   readAddr1/2             read port addresses
//   readData1/2             read port data (combinational)
//   readReady1/2            read port register not busy (combinational)
//   writeEnable/Addr/Data   write port
//   claimEnable/claimAddr   claim request: mark claimAddr busy
//   claimOk                 claim would be accepted (combinational)
//   flush                   clear all busy bits at the next edge
//   busyCount               registered number of busy registers
module reg_file_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] readAddr1,
   input  logic [ADDR_W-1:0] readAddr2,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic              readReady1,
   output logic              readReady2,
   input  logic              writeEnable,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [DATA_W-1:0] writeData,
   input  logic              claimEnable,
   input  logic [ADDR_W-1:0] claimAddr,
   output logic              claimOk,
   input  logic              flush,
   output logic [ADDR_W:0]   busyCount
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regFile [DEPTH];
   logic [DEPTH-1:0]  busyQ;
   logic [DEPTH-1:0]  busyD;
   logic [ADDR_W:0]   countD;
   logic              writeHit;
   logic              claimZero;
   logic              bypassOk;

   // Writes to the hardwired zero register are dropped entirely.
   assign writeHit  = writeEnable && !(ZERO_REG && (writeAddr == '0));
   assign claimZero = ZERO_REG && (claimAddr == '0);
   assign claimOk   = claimZero ? 1'b1 : !busyQ[claimAddr];
   // No forwarding while in reset so reads show the cleared state.
   assign bypassOk  = BYPASS && writeHit && reset;

   // Order matters: write clears, then an accepted claim sets (a claim only
   // succeeds on a non-busy register, so claim wins over a same-address
   // write), then flush overrides everything.
   always_comb begin
      busyD = busyQ;
      if (writeHit) begin
         busyD[writeAddr] = 1'b0;
      end
      if (claimEnable && claimOk && !claimZero) begin
         busyD[claimAddr] = 1'b1;
      end
      if (flush) begin
         busyD = '0;
      end
   end

   always_comb begin
      countD = '0;
      for (int i = 0; i < DEPTH; i++) begin
         countD = countD + {{ADDR_W{1'b0}}, busyD[i]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busyQ     <= '0;
         busyCount <= '0;
      end else begin
         busyQ     <= busyD;
         busyCount <= countD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regFile[i] <= '0;
         end
      end else if (writeHit) begin
         regFile[writeAddr] <= writeData;
      end
   end

   // Returns {ready, data} for one read port.
   function automatic logic [DATA_W:0] readPort(input logic [ADDR_W-1:0] addr);
      if (ZERO_REG && (addr == '0)) begin
         readPort = {1'b1, {DATA_W{1'b0}}};
      end else if (bypassOk && (writeAddr == addr)) begin
         readPort = {1'b1, writeData};
      end else begin
         readPort = {!busyQ[addr], regFile[addr]};
      end
   endfunction

   always_comb begin
      {readReady1, readData1} = readPort(readAddr1);
      {readReady2, readData2} = readPort(readAddr2);
   end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

   logic        clk;
   logic        reset;
   logic [4:0]  readAddr1, readAddr2, writeAddr, claimAddr;
   logic [31:0] writeData;
   logic        writeEnable, claimEnable, flush;

   // dut: ZERO_REG=1, BYPASS=1.  nb: ZERO_REG=0, BYPASS=0, same inputs.
   logic [31:0] rd1, rd2, nbRd1, nbRd2;
   logic        rdy1, rdy2, nbRdy1, nbRdy2, claimOk, nbClaimOk;
   logic [5:0]  busyCount, nbBusyCount;

   int checks;
   int failures;

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset),
      .readAddr1(readAddr1), .readAddr2(readAddr2),
      .readData1(rd1), .readData2(rd2),
      .readReady1(rdy1), .readReady2(rdy2),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
      .claimEnable(claimEnable), .claimAddr(claimAddr), .claimOk(claimOk),
      .flush(flush), .busyCount(busyCount)
   );

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) nb (
      .clk(clk), .reset(reset),
      .readAddr1(readAddr1), .readAddr2(readAddr2),
      .readData1(nbRd1), .readData2(nbRd2),
      .readReady1(nbRdy1), .readReady2(nbRdy2),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
      .claimEnable(claimEnable), .claimAddr(claimAddr), .claimOk(nbClaimOk),
      .flush(flush), .busyCount(nbBusyCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      writeEnable = 1'b0;
      claimEnable = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      readAddr1 = 5'd0; readAddr2 = 5'd0; writeAddr = 5'd0; claimAddr = 5'd0;
      writeData = 32'h0;
      step();
      step();
      checks++;
      if (busyCount !== 6'd0) begin
         failures++;
         $display("FAIL reset_count_in_reset: got %0d expected 0", busyCount);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         readAddr1 = 5'(i);
         readAddr2 = 5'(31 - i);
         #1;
         checks++;
         if (rd1 !== 32'h0 || rdy1 !== 1'b1 || rd2 !== 32'h0 || rdy2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_read r%0d: got %h/%b %h/%b expected 0/1 0/1",
                     i, rd1, rdy1, rd2, rdy2);
         end
      end
      checks++;
      if (busyCount !== 6'd0 || claimOk !== 1'b1) begin
         failures++;
         $display("FAIL reset_count: got %0d ok=%b expected 0 ok=1", busyCount, claimOk);
      end
   endtask

   task automatic test_write_hold();
      writeEnable = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF;
      step();
      writeEnable = 1'b0; writeData = 32'hFFFFFFFF; readAddr1 = 5'd5;
      step();
      checks++;
      if (rd1 !== 32'hDEADBEEF || rdy1 !== 1'b1) begin
         failures++;
         $display("FAIL write_hold: got %h/%b expected deadbeef/1", rd1, rdy1);
      end
      writeEnable = 1'b1; writeAddr = 5'd0; writeData = 32'h1234; readAddr1 = 5'd0;
      #1;
      checks++;
      if (rd1 !== 32'h0 || rdy1 !== 1'b1) begin
         failures++;
         $display("FAIL zero_reg_bypass: got %h/%b expected 0/1", rd1, rdy1);
      end
      step();
      idle();
      #1;
      checks++;
      if (rd1 !== 32'h0) begin
         failures++;
         $display("FAIL zero_reg_write: got %h expected 0", rd1);
      end
      checks++;
      if (nbRd1 !== 32'h1234) begin
         failures++;
         $display("FAIL nozero_r0_write: got %h expected 1234", nbRd1);
      end
   endtask

   task automatic test_bypass();
      writeEnable = 1'b1; writeAddr = 5'd7; writeData = 32'hA5A5A5A5; readAddr1 = 5'd7;
      #1;
      checks++;
      if (rd1 !== 32'hA5A5A5A5 || rdy1 !== 1'b1) begin
         failures++;
         $display("FAIL bypass_same_cycle: got %h/%b expected a5a5a5a5/1", rd1, rdy1);
      end
      checks++;
      if (nbRd1 !== 32'h0) begin
         failures++;
         $display("FAIL nobypass_old_value: got %h expected 0", nbRd1);
      end
      step();
      idle();
      #1;
      checks++;
      if (nbRd1 !== 32'hA5A5A5A5 || rd1 !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL bypass_next_cycle: got %h %h expected a5a5a5a5", rd1, nbRd1);
      end
   endtask

   task automatic test_scoreboard();
      claimEnable = 1'b1; claimAddr = 5'd3; readAddr2 = 5'd3;
      #1;
      checks++;
      if (claimOk !== 1'b1 || rdy2 !== 1'b1) begin
         failures++;
         $display("FAIL claim_ok: got ok=%b rdy=%b expected 1 1", claimOk, rdy2);
      end
      step();
      checks++;
      if (rdy2 !== 1'b0 || busyCount !== 6'd1 || claimOk !== 1'b0) begin
         failures++;
         $display("FAIL claim_busy: got rdy=%b cnt=%0d ok=%b expected 0 1 0",
                  rdy2, busyCount, claimOk);
      end
      step();
      checks++;
      if (busyCount !== 6'd1 || rdy2 !== 1'b0) begin
         failures++;
         $display("FAIL reclaim_rejected: got cnt=%0d rdy=%b expected 1 0", busyCount, rdy2);
      end
      claimEnable = 1'b0;
      writeEnable = 1'b1; writeAddr = 5'd3; writeData = 32'h33;
      #1;
      checks++;
      if (rdy2 !== 1'b1 || rd2 !== 32'h33 || nbRdy2 !== 1'b0) begin
         failures++;
         $display("FAIL writeback_bypass: got %h/%b nb=%b expected 33/1 nb=0",
                  rd2, rdy2, nbRdy2);
      end
      step();
      idle();
      #1;
      checks++;
      if (rdy2 !== 1'b1 || busyCount !== 6'd0 || nbBusyCount !== 6'd0) begin
         failures++;
         $display("FAIL writeback_clear: got rdy=%b cnt=%0d nbcnt=%0d expected 1 0 0",
                  rdy2, busyCount, nbBusyCount);
      end
   endtask

   task automatic test_simultaneous();
      // Claim + write to a free register: data lands and claim wins.
      claimEnable = 1'b1; claimAddr = 5'd9;
      writeEnable = 1'b1; writeAddr = 5'd9; writeData = 32'h99; readAddr1 = 5'd9;
      step();
      idle();
      #1;
      checks++;
      if (rd1 !== 32'h99 || rdy1 !== 1'b0 || busyCount !== 6'd1) begin
         failures++;
         $display("FAIL claim_write_free: got %h/%b cnt=%0d expected 99/0 1",
                  rd1, rdy1, busyCount);
      end
      // Claim + write to a busy register: claim rejected, write clears.
      claimEnable = 1'b1; claimAddr = 5'd9;
      writeEnable = 1'b1; writeAddr = 5'd9; writeData = 32'h9A;
      #1;
      checks++;
      if (claimOk !== 1'b0) begin
         failures++;
         $display("FAIL claim_write_busy_ok: got %b expected 0", claimOk);
      end
      step();
      idle();
      #1;
      checks++;
      if (rd1 !== 32'h9A || rdy1 !== 1'b1 || busyCount !== 6'd0) begin
         failures++;
         $display("FAIL claim_write_busy: got %h/%b cnt=%0d expected 9a/1 0",
                  rd1, rdy1, busyCount);
      end
      // Claims of r0: ignored with a zero register, honoured without.
      claimEnable = 1'b1; claimAddr = 5'd0; readAddr1 = 5'd0;
      step();
      claimEnable = 1'b0;
      #1;
      checks++;
      if (busyCount !== 6'd0 || rdy1 !== 1'b1 || nbBusyCount !== 6'd1 || nbRdy1 !== 1'b0) begin
         failures++;
         $display("FAIL claim_r0: got cnt=%0d rdy=%b nbcnt=%0d nbrdy=%b expected 0 1 1 0",
                  busyCount, rdy1, nbBusyCount, nbRdy1);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      // Claim r4 then r6, then flush with a claim of r8 and a write of r10.
      claimEnable = 1'b1; claimAddr = 5'd4;
      step();
      claimAddr = 5'd6;
      step();
      checks++;
      if (busyCount !== 6'd2) begin
         failures++;
         $display("FAIL two_claims: got %0d expected 2", busyCount);
      end
      claimAddr = 5'd8; flush = 1'b1;
      writeEnable = 1'b1; writeAddr = 5'd10; writeData = 32'hAA;
      readAddr1 = 5'd8; readAddr2 = 5'd10;
      step();
      idle();
      #1;
      checks++;
      if (busyCount !== 6'd0 || nbBusyCount !== 6'd0 || rdy1 !== 1'b1) begin
         failures++;
         $display("FAIL flush_claim: got cnt=%0d nbcnt=%0d rdy=%b expected 0 0 1",
                  busyCount, nbBusyCount, rdy1);
      end
      checks++;
      if (rd2 !== 32'hAA) begin
         failures++;
         $display("FAIL flush_write_data: got %h expected aa", rd2);
      end
   endtask

   task automatic test_async_reset();
      claimEnable = 1'b1; claimAddr = 5'd3;
      step();
      claimAddr = 5'd4;
      step();
      claimEnable = 1'b0;
      writeEnable = 1'b1; writeAddr = 5'd5; writeData = 32'h55;
      step();
      idle();
      readAddr1 = 5'd3; readAddr2 = 5'd5;
      #1;
      checks++;
      if (busyCount !== 6'd2 || rdy1 !== 1'b0 || rd2 !== 32'h55) begin
         failures++;
         $display("FAIL pre_reset_state: got cnt=%0d rdy=%b data=%h expected 2 0 55",
                  busyCount, rdy1, rd2);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (busyCount !== 6'd0 || rdy1 !== 1'b1 || rd2 !== 32'h0 || rdy2 !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: got cnt=%0d rdy=%b data=%h/%b expected 0 1 0/1",
                  busyCount, rdy1, rd2, rdy2);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (busyCount !== 6'd0 || rd2 !== 32'h0 || claimOk !== 1'b1) begin
         failures++;
         $display("FAIL after_reset: got cnt=%0d data=%h ok=%b expected 0 0 1",
                  busyCount, rd2, claimOk);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_write_hold();
      test_bypass();
      test_scoreboard();
      test_simultaneous();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
